float2fxp_pipe: RTL and testbench



---
 rtl/float2fxp_pipe.sv | 174 +++++++++++++++++
 tb/tb_float2fxp_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float2fxp_pipe.sv
// float2fxp_pipe: 3-stage streaming FP32 to signed Q(WOI.WOF) converter.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/fp32_i input stream;
//   out_valid/out_ready/fxp_o/ovf_o/nan_o output stream;
//   ovf_cnt saturating count of overflowing outputs, cnt_clr clears it.
module float2fxp_pipe #(
  parameter int WOI   = 9,
  parameter int WOF   = 7,
  parameter int RND   = 0,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        fp32_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WOI+WOF-1:0] fxp_o,
  output logic               ovf_o,
  output logic               nan_o,
  output logic [CNT_W-1:0]   ovf_cnt,
  input  logic               cnt_clr
);
  localparam int W  = WOI + WOF;
  localparam int G  = (RND != 0) ? 1 : 0;
  localparam int XW = (W + 2 > 25) ? W + 2 : 25;

  // Left-shift of {1,m} that yields the magnitude with G guard bits.
  localparam logic signed [10:0] SH_OFS = 11'(WOF + G - 150);
  // At or above this shift the magnitude is >= 2^W: certain overflow.
  localparam logic signed [10:0] SH_BIG = 11'(W - 23 + G);

  localparam logic [XW-1:0] NEG_LIM = XW'(1) << (W - 1);
  localparam logic [XW-1:0] POS_LIM = NEG_LIM - XW'(1);
  localparam logic [W-1:0]  FX_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  FX_MIN  = {1'b1, {(W-1){1'b0}}};

  logic v1, v2, v3;
  logic en1, en2, en3;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // S1: unpack and classify
  logic [7:0]         e_in;
  logic [22:0]        m_in;
  logic signed [10:0] sh_in;

  assign e_in  = fp32_i[30:23];
  assign m_in  = fp32_i[22:0];
  assign sh_in = $signed({3'b000, e_in}) + SH_OFS;

  logic               s1_sign, s1_nan, s1_inf, s1_zero, s1_big;
  logic [23:0]        s1_man;
  logic signed [10:0] s1_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
      s1_big  <= 1'b0;
      s1_man  <= '0;
      s1_sh   <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign <= fp32_i[31];
        s1_nan  <= (e_in == 8'hFF) && (m_in != '0);
        s1_inf  <= (e_in == 8'hFF) && (m_in == '0);
        s1_zero <= (e_in == 8'h00);
        s1_big  <= (sh_in >= SH_BIG);
        s1_man  <= {1'b1, m_in};
        s1_sh   <= sh_in;
      end
    end
  end

  // S2: align; right shifts past the mantissa width give zero
  logic signed [10:0] rsh;
  logic [XW-1:0]      mag_sh;

  always_comb begin
    rsh    = -s1_sh;
    mag_sh = '0;
    if (s1_sh >= 11'sd0)
      mag_sh = XW'(s1_man) << s1_sh[5:0];
    else if (rsh <= 11'sd23)
      mag_sh = XW'(s1_man) >> rsh[4:0];
  end

  logic          s2_sign, s2_nan, s2_inf, s2_zero, s2_big;
  logic [XW-1:0] s2_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_nan  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_big  <= 1'b0;
      s2_mag  <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
        s2_big  <= s1_big;
        s2_mag  <= mag_sh;
      end
    end
  end

  // S3: round, saturate, negate
  logic [XW-1:0] rmag;
  logic [W-1:0]  fx_c;
  logic          ovf_c, nan_c;

  always_comb begin
    rmag  = (G != 0) ? ((s2_mag + XW'(1)) >> 1) : s2_mag;
    fx_c  = '0;
    ovf_c = 1'b0;
    nan_c = 1'b0;
    if (s2_nan) begin
      nan_c = 1'b1;
    end else if (s2_inf || s2_big) begin
      ovf_c = 1'b1;
      fx_c  = s2_sign ? FX_MIN : FX_MAX;
    end else if (s2_zero) begin
      fx_c = '0;
    end else if (!s2_sign && rmag > POS_LIM) begin
      ovf_c = 1'b1;
      fx_c  = FX_MAX;
    end else if (s2_sign && rmag > NEG_LIM) begin
      ovf_c = 1'b1;
      fx_c  = FX_MIN;
    end else begin
      fx_c = s2_sign ? -rmag[W-1:0] : rmag[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3    <= 1'b0;
      fxp_o <= '0;
      ovf_o <= 1'b0;
      nan_o <= 1'b0;
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        fxp_o <= fx_c;
        ovf_o <= ovf_c;
        nan_o <= nan_c;
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      ovf_cnt <= '0;
    else if (v3 && out_ready && ovf_o && (ovf_cnt != '1))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_float2fxp_pipe.sv
// tb_float2fxp_pipe: scoreboard bench for float2fxp_pipe.
// Two instances in lockstep: A (RND=0, CNT_W=16), B (RND=1, CNT_W=4).
module tb_float2fxp_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cnt_clr;
  logic        out_ready = 1'b1;
  logic [31:0] fp32_i;

  logic        a_ir, a_ov, a_ovf, a_nan;
  logic [15:0] a_fxp, a_cnt;
  logic        b_ir, b_ov, b_ovf, b_nan;
  logic [15:0] b_fxp;
  logic [3:0]  b_cnt;

  float2fxp_pipe #(.WOI(9), .WOF(7), .RND(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir),
    .fp32_i(fp32_i), .out_valid(a_ov), .out_ready(out_ready),
    .fxp_o(a_fxp), .ovf_o(a_ovf), .nan_o(a_nan),
    .ovf_cnt(a_cnt), .cnt_clr(cnt_clr)
  );

  float2fxp_pipe #(.WOI(9), .WOF(7), .RND(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir),
    .fp32_i(fp32_i), .out_valid(b_ov), .out_ready(out_ready),
    .fxp_o(b_fxp), .ovf_o(b_ovf), .nan_o(b_nan),
    .ovf_cnt(b_cnt), .cnt_clr(cnt_clr)
  );

  // {ovf, nan, fxp[15:0]}
  logic [31:0] vfp [22];
  logic [17:0] va  [22];
  logic [17:0] vb  [22];

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    int          acc;
    bit          lat;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   or_mode = 0;
  int   bp_cyc = 0;
  bit   ir_low_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // out_ready: 0 = held high, 1 = random after a 5-cycle low hold, 2 = low
  always @(posedge clk) begin
    #1;
    if (or_mode == 1) begin
      bp_cyc++;
      if (bp_cyc <= 5) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
    end else begin
      bp_cyc    = 0;
      out_ready = (or_mode == 0);
    end
  end

  // monitor
  bit          stalled = 0;
  logic [17:0] held_a, held_b;
  exp_t        it;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(a_ov), 32'd1);
        chk("stall_data_a", 32'({a_ovf, a_nan, a_fxp}), 32'(held_a));
        chk("stall_data_b", 32'({b_ovf, b_nan, b_fxp}), 32'(held_b));
      end
      if (a_ov !== b_ov) begin
        chk("valid_lockstep", 32'(b_ov), 32'(a_ov));
      end
      if (a_ov && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'({a_ovf, a_nan, a_fxp}), 32'hDEAD);
        end else begin
          it = q.pop_front();
          chk($sformatf("out_a[%0d]", it.idx),
              32'({a_ovf, a_nan, a_fxp}), 32'(it.a));
          chk($sformatf("out_b[%0d]", it.idx),
              32'({b_ovf, b_nan, b_fxp}), 32'(it.b));
          if (it.lat) chk("latency", 32'(cyc - it.acc), 32'd3);
        end
      end
      stalled = a_ov && !out_ready;
      held_a  = {a_ovf, a_nan, a_fxp};
      held_b  = {b_ovf, b_nan, b_fxp};
    end
  end

  // Starts and ends at posedge+1.
  task automatic send(input int idx, input bit push, input bit lat);
    exp_t e;
    int   t;
    t        = 0;
    fp32_i   = vfp[idx];
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_ir && b_ir) begin
        if (push) begin
          e.a = va[idx]; e.b = vb[idx];
          e.acc = cyc; e.lat = lat; e.idx = idx;
          q.push_back(e);
        end
        break;
      end
      ir_low_seen = 1;
      t++;
      if (t > 100) begin
        chk("send_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (q.size() == 0 && !a_ov) break;
      t++;
      if (t > 200) break;
    end
    chk({nm, "_drain"}, 32'(q.size()), 32'd0);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vfp = '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h80000000,
            32'h43960000, 32'hC3800000, 32'h7F800000, 32'h7FC00000,
            32'h3BC00000, 32'hBBC00000, 32'h437FFF00, 32'hC3960000,
            32'hFF800000, 32'h00400000, 32'h40490FDB, 32'hBB800000,
            32'h3B800000, 32'h30000000, 32'h7F000000, 32'hFFC00000,
            32'hC37FFF00, 32'hC3800100};
    va  = '{18'h000C0, 18'h0FF40, 18'h00000, 18'h00000,
            18'h27FFF, 18'h08000, 18'h27FFF, 18'h10000,
            18'h00000, 18'h00000, 18'h07FFF, 18'h28000,
            18'h28000, 18'h00000, 18'h00192, 18'h00000,
            18'h00000, 18'h00000, 18'h27FFF, 18'h10000,
            18'h08001, 18'h28000};
    vb  = '{18'h000C0, 18'h0FF40, 18'h00000, 18'h00000,
            18'h27FFF, 18'h08000, 18'h27FFF, 18'h10000,
            18'h00001, 18'h0FFFF, 18'h27FFF, 18'h28000,
            18'h28000, 18'h00000, 18'h00192, 18'h0FFFF,
            18'h00001, 18'h00000, 18'h27FFF, 18'h10000,
            18'h08000, 18'h28000};

    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; fp32_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'({a_ov, b_ov}), 32'd0);
    chk("rst_data_a", 32'({a_ovf, a_nan, a_fxp}), 32'd0);
    chk("rst_data_b", 32'({b_ovf, b_nan, b_fxp}), 32'd0);
    chk("rst_cnt", 32'({a_cnt, b_cnt}), 32'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'({a_ir, b_ir}), 32'd3);
    sync();

    // basic values, latency 3
    for (int i = 0; i < 4; i++) send(i, 1, 1);
    wait_drain("basic");
    sync();

    // saturation / classification
    for (int i = 4; i < 8; i++) send(i, 1, 1);
    wait_drain("sat");
    chk("cnt_sat_a", 32'(a_cnt), 32'd2);
    chk("cnt_sat_b", 32'(b_cnt), 32'd2);
    sync();

    // rounding and boundaries
    for (int i = 8; i < 22; i++) send(i, 1, 1);
    wait_drain("round");
    chk("cnt_round_a", 32'(a_cnt), 32'd6);
    chk("cnt_round_b", 32'(b_cnt), 32'd7);
    sync();

    // idle clear
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_idle", 32'({a_cnt, b_cnt}), 32'd0);

    // back-pressure burst
    or_mode     = 1;
    ir_low_seen = 0;
    sync();
    for (int i = 0; i < 8; i++) send(i, 1, 0);
    wait_drain("bp");
    chk("bp_in_ready_dropped", 32'(ir_low_seen), 32'd1);
    or_mode = 0;
    sync();

    // saturating counter
    for (int i = 0; i < 20; i++) send(4, 1, 1);
    wait_drain("cnt");
    chk("cnt_a_22", 32'(a_cnt), 32'd22);
    chk("cnt_b_sat", 32'(b_cnt), 32'd15);

    // reset with 3 samples in flight
    or_mode = 2;
    sync();
    for (int i = 0; i < 3; i++) send(4, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'({a_ov, b_ov}), 32'd0);
    chk("midrst_cnt", 32'({a_cnt, b_cnt}), 32'd0);
    chk("midrst_in_ready", 32'({a_ir, b_ir}), 32'd3);
    sync();
    rst     = 1'b0;
    or_mode = 0;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", 32'(q.size()), 32'd0);

    // clear coinciding with an overflow transfer
    or_mode = 2;
    sync();
    send(6, 1, 0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (a_ov) break;
    end
    chk("clr_sample_ready", 32'(a_ov), 32'd1);
    or_mode = 0;
    sync();
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", 32'({a_cnt, b_cnt}), 32'd0);
    wait_drain("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
